// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - register scoreboard for long-latency execution channels
// Tracks each channel's pending destination and flags RAW/WAW/structural hazards for ID.
module hazard_scoreboard #(
   parameter int NUM_REGS = 32,
   parameter int REG_W    = 5,
   parameter int NUM_CH   = 3,
   parameter int HAS_X0   = 1,
   parameter int CNT_W    = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flush,
   input  logic [NUM_CH-1:0]       ch_issue,
   input  logic [NUM_CH*REG_W-1:0] ch_issue_rd,
   input  logic [NUM_CH-1:0]       ch_done,
   input  logic [3*REG_W-1:0]      id_rs,
   input  logic [2:0]              id_rs_valid,
   input  logic [REG_W-1:0]        id_rd,
   input  logic                    id_rd_valid,
   input  logic [NUM_CH-1:0]       id_ch_req,
   output logic                    raw_hazard,
   output logic                    waw_hazard,
   output logic                    struct_hazard,
   output logic                    stall,
   output logic [NUM_CH-1:0]       ch_busy,
   output logic [NUM_REGS-1:0]     pend_mask,
   output logic                    err,
   output logic [CNT_W-1:0]        stall_count
);

   typedef enum logic [1:0] {
      CH_IDLE  = 2'd0,
      CH_BUSY  = 2'd1,
      CH_DRAIN = 2'd2
   } ch_state_e;

   ch_state_e        state_q [NUM_CH];
   ch_state_e        state_d [NUM_CH];
   logic [REG_W-1:0] rd_q    [NUM_CH];
   logic [REG_W-1:0] rd_d    [NUM_CH];
   logic             err_q, err_d;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;

   logic [NUM_CH-1:0]   ch_live;
   logic [NUM_REGS-1:0] pend_w;
   logic                raw_w, waw_w, struct_w, stall_w;

   // An index can be pending only if it is in range and not the hardwired zero.
   function automatic logic trackable(input logic [REG_W-1:0] idx);
      logic t;
      t = 1'b0;
      for (int r = 0; r < NUM_REGS; r++) begin
         if (idx == REG_W'(r) && !(HAS_X0 != 0 && r == 0)) t = 1'b1;
      end
      return t;
   endfunction

   function automatic logic is_pend(input logic [REG_W-1:0] idx,
                                    input logic [NUM_REGS-1:0] mask);
      logic p;
      p = 1'b0;
      for (int r = 0; r < NUM_REGS; r++) begin
         if (idx == REG_W'(r) && mask[r]) p = 1'b1;
      end
      return p;
   endfunction

   always_comb begin
      ch_live = '0;
      pend_w  = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         ch_live[c] = (state_q[c] != CH_IDLE) && trackable(rd_q[c]);
         for (int r = 0; r < NUM_REGS; r++) begin
            if (ch_live[c] && rd_q[c] == REG_W'(r)) pend_w[r] = 1'b1;
         end
      end
   end

   // Hazards depend only on registered state and ID inputs.
   always_comb begin
      raw_w = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (id_rs_valid[i] && is_pend(id_rs[i*REG_W +: REG_W], pend_w)) raw_w = 1'b1;
      end
      waw_w    = id_rd_valid && is_pend(id_rd, pend_w);
      struct_w = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (id_ch_req[c] && state_q[c] != CH_IDLE) struct_w = 1'b1;
      end
      stall_w = raw_w | waw_w | struct_w;
   end

   always_comb begin
      logic [REG_W-1:0] issue_rd;
      logic             dup;
      issue_rd = '0;
      dup      = 1'b0;
      err_d    = err_q;
      for (int c = 0; c < NUM_CH; c++) begin
         state_d[c] = state_q[c];
         rd_d[c]    = rd_q[c];
         issue_rd   = ch_issue_rd[c*REG_W +: REG_W];
         dup        = 1'b0;
         for (int k = 0; k < NUM_CH; k++) begin
            if (k != c && ch_live[k] && rd_q[k] == issue_rd) dup = 1'b1;
         end
         if (flush) begin
            state_d[c] = CH_IDLE;
         end else begin
            case (state_q[c])
               CH_IDLE: begin
                  if (ch_issue[c]) begin
                     state_d[c] = CH_BUSY;
                     rd_d[c]    = issue_rd;
                     if (dup) err_d = 1'b1;
                  end
                  if (ch_done[c]) err_d = 1'b1;
               end
               CH_BUSY: begin
                  if (ch_done[c]) state_d[c] = CH_DRAIN;
                  if (ch_issue[c]) err_d = 1'b1;
               end
               CH_DRAIN: begin
                  state_d[c] = CH_IDLE;
                  if (ch_issue[c]) begin
                     state_d[c] = CH_BUSY;
                     rd_d[c]    = issue_rd;
                     if (dup) err_d = 1'b1;
                  end
                  if (ch_done[c]) err_d = 1'b1;
               end
               default: state_d[c] = CH_IDLE;
            endcase
         end
      end
      stall_count_d = stall_count_q;
      if (stall_w && stall_count_q != {CNT_W{1'b1}}) stall_count_d = stall_count_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int c = 0; c < NUM_CH; c++) begin
            state_q[c] <= CH_IDLE;
            rd_q[c]    <= '0;
         end
         err_q         <= 1'b0;
         stall_count_q <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            state_q[c] <= state_d[c];
            rd_q[c]    <= rd_d[c];
         end
         err_q         <= err_d;
         stall_count_q <= stall_count_d;
      end
   end

   always_comb begin
      ch_busy = '0;
      for (int c = 0; c < NUM_CH; c++) ch_busy[c] = (state_q[c] != CH_IDLE);
   end

   assign raw_hazard    = raw_w;
   assign waw_hazard    = waw_w;
   assign struct_hazard = struct_w;
   assign stall         = stall_w;
   assign pend_mask     = pend_w;
   assign err           = err_q;
   assign stall_count   = stall_count_q;

endmodule
